fnd_scan: RTL and testbench
===========================

Name: fnd_scan

Overview:
- Display stage directly downstream of the seconds counter chain (clock divider → 0..59 counter).
- Takes three 6-bit count values (e.g. sec/min/hour-style fields, each 0..59) and time-multiplexes them onto a 6-digit common-anode 7-segment display.
- Each field is split into tens and ones digits. A scan counter steps one digit per SCAN_DIV clocks.
- Inputs are snapshotted once per frame, so a mid-frame counter change never tears the display.

Parameters:
- SCAN_DIV, 50000, clocks per digit slot (1 kHz digit rate at 50 MHz); legal range 1..2^20.
- CNT_W, 20, width of the internal scan divider counter; must hold SCAN_DIV-1.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  synchronous, active-low reset.
- val_0  input  6  field 0, shown on digits 1 (tens) and 0 (ones).
- val_1  input  6  field 1, shown on digits 3 (tens) and 2 (ones).
- val_2  input  6  field 2, shown on digits 5 (tens) and 4 (ones).
- seg  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}.
- com  output  6  digit enable, active-low one-hot; com[i] low = digit i lit.

Behaviour:
- Clock and reset: one clock (clk). Reset rst_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset values: seg = 7'b1111111, com = 6'b111111, divider = 0, digit index = 5, snapshot registers = 0.
- Divider: counts 0..SCAN_DIV-1 and wraps to 0. A tick occurs on the edge where the divider equals SCAN_DIV-1.
- On each tick:
  - digit index advances 0→1→…→5→0.
  - seg and com are updated from a registered output (latency one clock from the tick condition).
  - First tick after reset release selects digit 0. With rst_n high from edge 1, digit 0 is lit after edge SCAN_DIV, digit 1 after edge 2*SCAN_DIV, and so on.
- Frame snapshot: on a tick whose next index is 0, snap_0..snap_2 load val_0..val_2. Digit 0's segments on that tick come from the same sampled values. All six digits of a frame therefore come from one sample.
- Digit data:
  - tens = snap/10, ones = snap%10, computed by constant division/compare with no multi-cycle arithmetic.
  - Values 60..63 are not clamped: tens = 6, ones = 0..3.
- Decoder patterns (active-low gfedcba):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - blank = 1111111
- com always has exactly one bit low after the first tick. Between ticks, seg and com hold.
- SCAN_DIV = 1: a tick occurs every clock and the digit index advances every edge.
- Reset asserted mid-frame: on the next edge all outputs return to reset values and the frame restarts at digit 0 after SCAN_DIV edges.
- Input changes between snapshots have no visible effect until the next frame start.

Optional Feature:
- Macro: FND_LZB_EN (leading-zero blanking).
- Defined: a tens digit whose value is 0 is driven blank (seg = 1111111). Its com bit is still asserted so the scan timing is unchanged.
- Undefined: a tens digit of 0 shows the pattern for "0" (1000000).
- Ones digits are never blanked in either case.

Decomposition:
- Package fnd_pkg holds:
  - NUM_DIGITS = 6.
  - Segment constants SEG_0..SEG_9 and SEG_BLANK.
  - Bit-index constants for g..a.
- One sub-module, fnd_dec: purely combinational, 4-bit digit in → 7-bit active-low segments out; codes 10..15 → SEG_BLANK.
- fnd_scan instantiates one fnd_dec on the muxed digit.

Test Plan:
- Reset and first slot: SCAN_DIV=4, rst_n=0 for 2 edges, then 1.
  - Required: seg=1111111, com=111111 through edge 3.
  - Required at edge 4: com=111110 and seg shows val_0 ones.
- Full frame: val_0=37, val_1=5, val_2=59, SCAN_DIV=4.
  - Required across six ticks: com steps 111110, 111101, 111011, 110111, 101111, 011111.
  - Required seg sequence: 1111000(7), 0110000(3), 0010010(5), 1000000(0), 0010000(9), 0010010(5).
- Snapshot integrity: change val_0 from 37 to 42 while com=111011.
  - Required: digits 0/1 keep showing 7/3 until the next frame start, then 2/4.
- Boundary values: val_0=0, then val_0=63.
  - Required for 0: both digits show 1000000 (FND_LZB_EN off); with FND_LZB_EN on, digit 1 shows 1111111 while com[1] is still low.
  - Required for 63: tens shows 0000010 (6), ones shows 0110000 (3).
- Mid-frame reset: assert rst_n=0 for one edge while com=110111.
  - Required: next edge seg=1111111, com=111111.
  - Required: SCAN_DIV edges after release, com=111110.
- SCAN_DIV=1: com rotates one position per clock with no idle cycle after the first edge.

Source files
------------

// File: rtl/fnd_pkg.sv
// Shared constants for the 6-digit 7-segment scan block: digit count,
// active-low segment patterns (bit order {g,f,e,d,c,b,a}), segment bit
// indices and the tens/ones split used for 0..63 field values.
package fnd_pkg;

    localparam int NUM_DIGITS = 6;

    // Segment bit positions inside the 7-bit seg word
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Active-low patterns, gfedcba
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Digit code fed to the decoder to force a dark digit
    localparam logic [3:0] CODE_BLANK = 4'hF;

    // Tens digit of a 0..63 value by constant compares; 60..63 give 6.
    function automatic logic [3:0] tens_of(input logic [5:0] v);
        logic [3:0] t;
        if      (v >= 6'd60) t = 4'd6;
        else if (v >= 6'd50) t = 4'd5;
        else if (v >= 6'd40) t = 4'd4;
        else if (v >= 6'd30) t = 4'd3;
        else if (v >= 6'd20) t = 4'd2;
        else if (v >= 6'd10) t = 4'd1;
        else                 t = 4'd0;
        return t;
    endfunction

    // Ones digit: value minus ten times the tens digit (constant multiply).
    function automatic logic [3:0] ones_of(input logic [5:0] v);
        logic [5:0] ten_x;
        ten_x = 6'({2'b00, tens_of(v)} * 6'd10);
        return 4'(v - ten_x);
    endfunction

endpackage

// File: rtl/fnd_dec.sv
// Combinational BCD to active-low 7-segment decoder; codes 10..15 are dark.
module fnd_dec
    import fnd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Pattern lookup
    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/fnd_scan.sv
// Time-multiplexed driver for a 6-digit common-anode 7-segment display.
// Three 0..63 fields are shown as tens/ones pairs; a snapshot taken at each
// frame start keeps all six digits of a frame consistent.
// Build option: define FND_LZB_EN to blank tens digits whose value is 0.
module fnd_scan
    import fnd_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int CNT_W    = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] val_0,
    input  logic [5:0] val_1,
    input  logic [5:0] val_2,
    output logic [6:0] seg,
    output logic [5:0] com
);

    localparam logic [CNT_W-1:0] DIV_MAX  = CNT_W'(SCAN_DIV - 1);
    localparam logic [2:0]       LAST_IDX = 3'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] div;
    logic [2:0]       idx;
    logic [2:0]       next_idx;
    logic             tick;
    logic             frame_start;
    logic [5:0]       snap_0;
    logic [5:0]       snap_1;
    logic [5:0]       snap_2;
    logic [5:0]       field;
    logic [3:0]       tens;
    logic [3:0]       ones;
    logic [3:0]       code;
    logic [6:0]       seg_next;

    assign tick        = (div == DIV_MAX);
    assign next_idx    = (idx == LAST_IDX) ? 3'd0 : 3'(idx + 3'd1);
    assign frame_start = (next_idx == 3'd0);

    // Divider: 0..SCAN_DIV-1, wrapping on tick
    always_ff @(posedge clk) begin
        if (!rst_n)    div <= '0;
        else if (tick) div <= '0;
        else           div <= div + 1'b1;
    end

    // Field for the digit about to be shown; digit 0 reads the live input
    // so it matches the snapshot being taken on the same edge.
    always_comb begin
        field = snap_0;
        case (next_idx[2:1])
            2'd0:    field = frame_start ? val_0 : snap_0;
            2'd1:    field = snap_1;
            2'd2:    field = snap_2;
            default: field = snap_0;
        endcase
    end

    assign tens = tens_of(field);
    assign ones = ones_of(field);

    // Odd digit positions carry tens, even positions carry ones
    always_comb begin
        code = next_idx[0] ? tens : ones;
`ifdef FND_LZB_EN
        if (next_idx[0] && (tens == 4'd0)) code = CODE_BLANK;
`endif
    end

    fnd_dec u_dec (
        .digit (code),
        .seg   (seg_next)
    );

    // Scan index, frame snapshot and registered display drive
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx    <= LAST_IDX;
            snap_0 <= '0;
            snap_1 <= '0;
            snap_2 <= '0;
            seg    <= SEG_BLANK;
            com    <= '1;
        end else if (tick) begin
            idx <= next_idx;
            seg <= seg_next;
            com <= ~(6'b000001 << next_idx);
            if (frame_start) begin
                snap_0 <= val_0;
                snap_1 <= val_1;
                snap_2 <= val_2;
            end
        end
    end

endmodule

// File: tb/tb_fnd_scan.sv
// Directed bench for fnd_scan: a SCAN_DIV=4 instance walks reset, full
// frames, snapshot behaviour, boundary values and a mid-frame reset; a
// SCAN_DIV=1 instance on the same inputs checks per-clock rotation.
module tb_fnd_scan;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] val_0 = 6'd37;
    logic [5:0] val_1 = 6'd5;
    logic [5:0] val_2 = 6'd59;
    logic [6:0] seg;
    logic [5:0] com;
    logic [6:0] seg_f;
    logic [5:0] com_f;

    int checks   = 0;
    int failures = 0;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;
`ifdef FND_LZB_EN
    localparam logic [6:0] T0 = SB;
`else
    localparam logic [6:0] T0 = S0;
`endif

    fnd_scan #(.SCAN_DIV(4), .CNT_W(20)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .val_0 (val_0),
        .val_1 (val_1),
        .val_2 (val_2),
        .seg   (seg),
        .com   (com)
    );

    fnd_scan #(.SCAN_DIV(1), .CNT_W(20)) u_fast (
        .clk   (clk),
        .rst_n (rst_n),
        .val_0 (val_0),
        .val_1 (val_1),
        .val_2 (val_2),
        .seg   (seg_f),
        .com   (com_f)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic slot(input int n, input string tag, input logic [5:0] ec, input logic [6:0] es);
        repeat (n) step();
        chk({tag, "_com"}, {1'b0, com}, {1'b0, ec});
        chk({tag, "_seg"}, seg, es);
    endtask

    logic [5:0] fast_com [7];
    logic [6:0] fast_seg [7];

    initial begin
        // Reset held for two edges
        step();
        step();
        chk("rst_seg", seg, SB);
        chk("rst_com", {1'b0, com}, 7'b0111111);
        chk("rst_fast_com", {1'b0, com_f}, 7'b0111111);
        rst_n = 1'b1;

        for (int i = 1; i <= 3; i++) begin
            step();
            chk("pre_tick_seg", seg, SB);
            chk("pre_tick_com", {1'b0, com}, 7'b0111111);
        end

        // Edge 4 after release: first tick selects digit 0
        step();
        chk("f1_d0_com", {1'b0, com}, 7'b0111110);
        chk("f1_d0_seg", seg, S7);
        chk("fast_e4_com", {1'b0, com_f}, 7'b0110111);
        chk("fast_e4_seg", seg_f, T0);
        step();
        chk("hold_com", {1'b0, com}, 7'b0111110);
        chk("hold_seg", seg, S7);

        slot(3, "f1_d1", 6'b111101, S3);
        slot(4, "f1_d2", 6'b111011, S5);
        slot(4, "f1_d3", 6'b110111, T0);
        slot(4, "f1_d4", 6'b101111, S9);
        slot(4, "f1_d5", 6'b011111, S5);

        // Frame 2: change val_0 after digit 0, snapshot must hold tens of 37
        slot(4, "f2_d0", 6'b111110, S7);
        val_0 = 6'd42;
        slot(4, "f2_d1", 6'b111101, S3);
        slot(4, "f2_d2", 6'b111011, S5);
        slot(4, "f2_d3", 6'b110111, T0);
        slot(4, "f2_d4", 6'b101111, S9);
        slot(4, "f2_d5", 6'b011111, S5);

        // Frame 3 picks up 42
        slot(4, "f3_d0", 6'b111110, S2);
        slot(4, "f3_d1", 6'b111101, S4);
        val_0 = 6'd0;
        slot(4, "f3_d2", 6'b111011, S5);
        slot(12, "f3_d5", 6'b011111, S5);

        // Frame 4: value 0, tens digit still has its com bit low
        slot(4, "f4_d0", 6'b111110, S0);
        slot(4, "f4_d1", 6'b111101, T0);
        val_0 = 6'd63;
        slot(16, "f4_d5", 6'b011111, S5);

        // Frame 5: value 63 is not clamped
        slot(4, "f5_d0", 6'b111110, S3);
        slot(4, "f5_d1", 6'b111101, S6);
        slot(4, "f5_d2", 6'b111011, S5);
        slot(4, "f5_d3", 6'b110111, T0);

        // Mid-frame reset for one edge
        rst_n = 1'b0;
        step();
        chk("mrst_seg", seg, SB);
        chk("mrst_com", {1'b0, com}, 7'b0111111);
        chk("mrst_fast_seg", seg_f, SB);
        chk("mrst_fast_com", {1'b0, com_f}, 7'b0111111);
        rst_n = 1'b1;

        fast_com = '{6'b111110, 6'b111101, 6'b111011, 6'b110111,
                     6'b101111, 6'b011111, 6'b111110};
        fast_seg = '{S3, S6, S5, T0, S9, S5, S3};
        for (int k = 0; k < 7; k++) begin
            step();
            chk($sformatf("fast_com_%0d", k), {1'b0, com_f}, {1'b0, fast_com[k]});
            chk($sformatf("fast_seg_%0d", k), seg_f, fast_seg[k]);
            if (k < 3) begin
                chk($sformatf("mrst_idle_com_%0d", k), {1'b0, com}, 7'b0111111);
            end else if (k == 3) begin
                chk("mrst_d0_com", {1'b0, com}, 7'b0111110);
                chk("mrst_d0_seg", seg, S3);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
